// File: rtl/rsc_encoder_gen_if.sv
// Stream and control bundle between a turbo datapath driver and the RSC constituent encoder.
interface rsc_encoder_gen_if #(
  parameter int M     = 3,
  parameter int LEN_W = 13
);
  logic             start;
  logic [LEN_W-1:0] k_len;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_sys;
  logic             out_par;
  logic             out_tail;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [M-1:0]     enc_state;

  modport master (
    output start, k_len, in_bit, in_valid, out_ready,
    input  in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, done, enc_state
  );

  modport slave (
    input  start, k_len, in_bit, in_valid, out_ready,
    output in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, done, enc_state
  );
endinterface

// File: rtl/rsc_encoder_gen.sv
// Parametrised RSC constituent encoder: k_len data beats then M termination beats,
// single-entry registered output with full valid/ready backpressure.
//
// state | meaning
// IDLE  | waiting for start with nonzero k_len
// DATA  | encoding input bits until k_len accepted
// TAIL  | emitting M trellis-termination beats
// DRAIN | waiting for the final tail beat to transfer
module rsc_encoder_gen #(
  parameter int         M       = 3,
  parameter logic [M:0] FB_POLY = 4'hD,
  parameter logic [M:0] FF_POLY = 4'hB,
  parameter int         LEN_W   = 13
) (
  input logic clk,
  input logic aclr,
  rsc_encoder_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

  state_t           state;
  logic [1:M]       s;
  logic [LEN_W-1:0] k_lat;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [2:0]       tcnt;
  logic             out_valid_q;
  logic             out_sys_q;
  logic             out_par_q;
  logic             out_tail_q;
  logic             out_last_q;
  logic             busy_q;
  logic             done_q;
  logic             adv;
  logic             fb;
  logic             ff_s;
  logic             a_dat;
  logic             par_dat;
  logic             tail_end;

  always_comb begin
    fb   = 1'b0;
    ff_s = 1'b0;
    for (int i = 1; i <= M; i++) begin
      fb   = fb ^ (FB_POLY[i] & s[i]);
      ff_s = ff_s ^ (FF_POLY[i] & s[i]);
    end
  end

  assign adv      = !out_valid_q || bus.out_ready;
  assign a_dat    = bus.in_bit ^ fb;
  assign par_dat  = (FF_POLY[0] & a_dat) ^ ff_s;
  assign cnt_nxt  = cnt + LEN_W'(1);
  assign tail_end = (tcnt == 3'(M - 1));

  always_ff @(posedge clk) begin
    if (aclr) begin
      state       <= IDLE;
      s           <= '0;
      k_lat       <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      out_valid_q <= 1'b0;
      out_sys_q   <= 1'b0;
      out_par_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.k_len != '0)) begin
            k_lat  <= bus.k_len;
            s      <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= DATA;
          end
        end
        DATA: begin
          if (bus.in_valid && adv) begin
            out_valid_q <= 1'b1;
            out_sys_q   <= bus.in_bit;
            out_par_q   <= par_dat;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
            s           <= {a_dat, s[1:M-1]};
            cnt         <= cnt_nxt;
            if (cnt_nxt == k_lat) begin
              tcnt  <= '0;
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          // Feeding u = fb makes the register input zero, flushing the trellis.
          if (adv) begin
            out_valid_q <= 1'b1;
            out_sys_q   <= fb;
            out_par_q   <= ff_s;
            out_tail_q  <= 1'b1;
            out_last_q  <= tail_end;
            s           <= {1'b0, s[1:M-1]};
            tcnt        <= tcnt + 3'd1;
            if (tail_end) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == DATA) && adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sys   = out_sys_q;
  assign bus.out_par   = out_par_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.enc_state = s;

endmodule

// File: tb/tb_rsc_encoder_gen.sv
// Bench for rsc_encoder_gen: table vectors plus an LTE reference model feeding a beat scoreboard.
module tb_rsc_encoder_gen;
  localparam int LEN_W = 13;

  typedef struct {
    logic       in_bit;
    logic       sys;
    logic       par;
    logic       tail;
    logic       last;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    logic       sys;
    logic       par;
    logic       tail;
    logic       last;
    logic [2:0] st;
  } beat_t;

  logic clk;
  logic aclr;

  rsc_encoder_gen_if #(.M(3), .LEN_W(LEN_W)) bus ();

  rsc_encoder_gen #(.M(3), .FB_POLY(4'hD), .FF_POLY(4'hB), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  int    beat_cnt = 0;
  int    done_cnt = 0;
  int    exp_done = 0;
  int    rdy_mode = 0;
  int    pidx = 0;
  bit    mon_en = 1'b1;
  bit    stall_prev = 1'b0;
  logic  [3:0] held;
  logic  [5:0] rdy_pat = 6'b101001;
  logic  ms1, ms2, ms3;
  beat_t exp_q[$];
  beat_t e;
  vec_t  tbl[7];
  bit    blk[6144];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic abort(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired waiting for DUT", nm);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // LTE reference: g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3 (parity)
  task automatic model_push(input logic u, input logic tl, input logic lst);
    logic a;
    beat_t b;
    a = u ^ ms2 ^ ms3;
    b.sys  = u;
    b.par  = a ^ ms1 ^ ms3;
    b.tail = tl;
    b.last = lst;
    ms3 = ms2;
    ms2 = ms1;
    ms1 = a;
    b.st = {ms1, ms2, ms3};
    exp_q.push_back(b);
  endtask

  task automatic push_tbl(input int i);
    beat_t b;
    b.sys  = tbl[i].sys;
    b.par  = tbl[i].par;
    b.tail = tbl[i].tail;
    b.last = tbl[i].last;
    b.st   = tbl[i].st;
    exp_q.push_back(b);
  endtask

  // Caller times the start pulse; returns mid-cycle while done is high.
  task automatic run_block(input int k, input bit use_tbl, input int start_at);
    int t;
    int b0;
    b0 = beat_cnt;
    ms1 = 1'b0; ms2 = 1'b0; ms3 = 1'b0;
    bus.start = 1'b1;
    bus.k_len = LEN_W'(k);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.k_len = 13'd2;
    chk("busy_after_start", bus.busy, 1);
    for (int i = 0; i < k; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = use_tbl ? tbl[i].in_bit : blk[i];
      if (i == start_at) begin
        bus.start = 1'b1;
        bus.k_len = 13'd3;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.in_ready && t < 2000);
      if (!bus.in_ready) abort("in_ready_wait");
      if (use_tbl) push_tbl(i);
      else model_push(bus.in_bit, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (use_tbl) push_tbl(k + j);
      else model_push(ms2 ^ ms3, 1'b1, j == 2);
    end
    exp_done++;
    t = 0;
    while (!bus.done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) abort("done_wait");
    chk("beats_per_block", beat_cnt - b0, k + 3);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = rdy_pat[pidx % 6];
          pidx++;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_beat", {bus.out_sys, bus.out_par, bus.out_tail, bus.out_last}, held);
      end
      if (bus.done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got beat %0d, required none", beat_cnt);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", beat_cnt),
              {bus.out_sys, bus.out_par, bus.out_tail, bus.out_last, bus.enc_state},
              {e.sys, e.par, e.tail, e.last, e.st});
        end
        beat_cnt++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      if (stall_prev) begin
        held = {bus.out_sys, bus.out_par, bus.out_tail, bus.out_last};
        chk("in_ready_stall", bus.in_ready, 0);
      end
    end
  end

  initial begin
    int b0;
    int t;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000};

    aclr = 1'b1;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.in_bit = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_enc_state", bus.enc_state, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_bits", {bus.out_sys, bus.out_par, bus.out_tail, bus.out_last}, 0);
    aclr = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Reference block, free-flowing then with backpressure pattern
    run_block(4, 1'b1, -1);
    rdy_mode = 1;
    run_block(4, 1'b1, -1);
    rdy_mode = 0;

    // Zero-length start is ignored
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k_len = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      chk("klen0_busy", bus.busy, 0);
      chk("klen0_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end

    // Start during DATA is ignored
    for (int i = 0; i < 8; i++) blk[i] = bit'($urandom_range(0, 1));
    run_block(8, 1'b0, 3);

    // Mid-block clear after the second beat
    @(posedge clk); #1;
    b0 = beat_cnt;
    ms1 = 1'b0; ms2 = 1'b0; ms3 = 1'b0;
    bus.start = 1'b1;
    bus.k_len = 13'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = (i == 0);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.in_ready && t < 100);
      if (!bus.in_ready) abort("aclr_in_ready_wait");
      model_push(bus.in_bit, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_bit = 1'b0;
    t = 0;
    while (beat_cnt - b0 < 2 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (beat_cnt - b0 < 2) abort("aclr_beat_wait");
    mon_en = 1'b0;
    aclr = 1'b1;
    @(posedge clk); #1;
    chk("aclr_out_valid", bus.out_valid, 0);
    chk("aclr_busy", bus.busy, 0);
    chk("aclr_enc_state", bus.enc_state, 0);
    aclr = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(posedge clk); #1;
      chk("aclr_no_done", bus.done, 0);
    end
    mon_en = 1'b1;
    run_block(4, 1'b1, -1);

    // Maximum LTE length of zeros, then back-to-back start on the done cycle
    for (int i = 0; i < 6144; i++) blk[i] = 1'b0;
    @(posedge clk); #1;
    run_block(6144, 1'b0, -1);
    run_block(40, 1'b0, -1);

    // Random block with random downstream stalls
    for (int i = 0; i < 1056; i++) blk[i] = bit'($urandom_range(0, 1));
    rdy_mode = 2;
    @(posedge clk); #1;
    run_block(1056, 1'b0, -1);
    rdy_mode = 0;

    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, exp_done);
    chk("final_busy", bus.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rsc_encoder_gen.md
Name: rsc_encoder_gen

Overview:
- Parametrised recursive systematic convolutional (RSC) constituent encoder for the turbo encoder datapath; next generation of the fixed 3-register LTE constituent encoder.
- Generator polynomials, memory depth and maximum block length are parameters; block length is a runtime input.
- Emits one systematic/parity pair per accepted input bit, then M trellis-termination (tail) beats.
- Input and output are valid/ready streams with full backpressure.

Parameters:
M, 3, encoder memory (number of state registers), 2..6
FB_POLY, 4'hD, feedback polynomial, width M+1; bit i = coefficient of D^i; bit 0 must be 1 (LTE g0 = 1+D^2+D^3)
FF_POLY, 4'hB, feedforward/parity polynomial, width M+1, same bit order (LTE g1 = 1+D+D^3)
LEN_W, 13, width of block-length input and internal bit counter

Ports:
clk  in  1  clock; all logic on rising edge
aclr  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a block when idle
k_len  in  LEN_W  block length in bits, sampled on accepted start
in_bit  in  1  input data bit
in_valid  in  1  in_bit valid
in_ready  out  1  encoder accepts in_bit this cycle
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_sys  out  1  systematic bit (tail: feedback-derived tail bit)
out_par  out  1  parity bit
out_tail  out  1  current beat is a tail beat
out_last  out  1  current beat is the final tail beat of the block
busy  out  1  high from accepted start until final tail beat is transferred
done  out  1  one-cycle pulse on the cycle after the final tail beat transfers
enc_state  out  M  state registers s[1..M] (s[1] = most recent), debug

Behaviour:
- Reset (aclr=1 at clock edge): FSM=IDLE, s=0, bit counter=0, out_valid=0, out_sys=0, out_par=0, out_tail=0, out_last=0, busy=0, done=0. aclr has priority over every other input, including mid-block; the partial block is discarded and no done pulse is produced.
- FSM states:
  - IDLE: start=1 and k_len!=0 -> latch k_len, clear s and counter, go to DATA, busy=1 from the next cycle.
  - start with k_len=0 is ignored. start in any state other than IDLE is ignored.
- Advance condition: adv = (!out_valid || out_ready). The output register is single-entry; a new beat is loaded only when adv=1.
- DATA:
  - in_ready = adv.
  - On in_valid && in_ready, with fb = XOR over i=1..M of FB_POLY[i]&s[i]:
    - a = in_bit ^ fb.
    - par = (FF_POLY[0]&a) ^ XOR over i=1..M of FF_POLY[i]&s[i].
    - Load out_sys=in_bit, out_par=par, out_tail=0, out_last=0, out_valid=1.
    - Shift s: s[1]<=a, s[i]<=s[i-1]. Counter increments.
  - When the accepted bit is the k_len-th, go to TAIL with tail counter=0.
- TAIL:
  - in_ready=0.
  - Each adv cycle: u = fb (so a=0); load out_sys=u, out_par = XOR over i=1..M of FF_POLY[i]&s[i], out_tail=1, out_valid=1. Shift a=0 into s.
  - After M tail beats, s is all-zero. out_last=1 on the M-th tail beat.
  - After loading the M-th tail beat, go to DRAIN.
- DRAIN: wait for the final beat to transfer (out_valid && out_ready). Then busy<=0, done<=1 for one cycle, FSM=IDLE.
- out_valid with no transfer: the beat holds stable (all out_* unchanged) until out_ready.
- Latency: the output beat is registered one cycle after input acceptance; throughput is 1 bit/cycle with out_ready held high.
- Total beats per block = k_len + M.
- The counter compares against the latched k_len only; changes on k_len mid-block have no effect.
- A back-to-back start is accepted on the done cycle (FSM is already IDLE).

Test Plan:
1. Default params, start k_len=4, in_bits 1,0,0,0, out_ready=1 -> out_sys 1,0,0,0,1,0,1; out_par 1,1,1,1,1,1,1; out_tail 0,0,0,0,1,1,1; out_last only on beat 7; enc_state after beat 4 = {s1,s2,s3}={1,1,0}; enc_state=0 after beat 7; done pulses once.
2. k_len=6144, all-zero input -> 6147 beats, all out_sys=out_par=0, 3 tail beats, done pulse. Repeat with k_len=40 immediately on the done cycle -> accepted, 43 beats.
3. Backpressure: scenario 1 with out_ready toggled 1,0,0,1,0,1,... -> identical beat sequence; each beat held stable while out_ready=0; in_ready=0 whenever out_valid && !out_ready.
4. Ignored starts: start with k_len=0 -> busy stays 0, no beats. start pulse during DATA -> no effect on beat count or values.
5. aclr asserted after beat 2 of a k_len=4 block -> next cycle out_valid=0, busy=0, enc_state=0, no done pulse. A fresh scenario-1 block then reproduces scenario 1 exactly.
6. Random 1056-bit block vs. golden model with M=3, FB=4'hD, FF=4'hB and random out_ready -> bit-exact match on all 1059 beats; enc_state=0 after the last tail beat.
